// File: rtl/axi4_slave_pkg.sv
// Shared constants, FSM state types and the burst/size legality check
// for the AXI4 burst slave memory.
package axi4_slave_pkg;

  localparam logic [1:0] FIXED       = 2'b00;
  localparam logic [1:0] INCR        = 2'b01;
  localparam logic [1:0] WRAP        = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Only FIXED/INCR bursts of full 32-bit beats are serviced.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst == WRAP) || (burst == 2'b11) || (size != 3'd2);
  endfunction

endpackage

// File: rtl/axi4_slave_ram.sv
// Word-addressed RAM split into four byte lanes: one byte-enabled write
// port, one registered read port with read-before-write behaviour.
module axi4_slave_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rd_q;

    // Byte-lane write plus registered read; a same-cycle read sees old data.
    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) mem[waddr] <= wdata[gi*8 +: 8];
      if (re)              rd_q       <= mem[raddr];
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 slave backed by internal RAM. Independent write and read FSMs,
// one outstanding transaction per direction, FIXED/INCR bursts only.
module axi4_burst_slave_mem
  import axi4_slave_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int WA = C_S_AXI_ADDR_WIDTH - 2;

  wr_state_t                   wr_state_q, wr_state_d;
  logic                        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic                        wr_err_q, wr_err_d;
  logic [WA-1:0]               wr_addr_q, wr_addr_d;
  logic [7:0]                  wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic [1:0]                  wr_burst_q, wr_burst_d;

  rd_state_t                   rd_state_q, rd_state_d;
  logic                        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic                        rd_err_q, rd_err_d;
  logic [WA-1:0]               rd_addr_q, rd_addr_d;
  logic [7:0]                  rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]                  rd_burst_q, rd_burst_d;

  logic          ram_we, ram_re;
  logic [WA-1:0] ram_raddr, rd_next;
  logic [31:0]   ram_rdata;

  // Byte offsets are ignored: every beat is a full aligned word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign ram_we = (wr_state_q == W_DATA) && S_AXI_WVALID && wready_q && !wr_err_q;

  axi4_slave_ram #(.AW(WA)) u_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .wstrb (S_AXI_WSTRB),
    .waddr (wr_addr_q),
    .wdata (S_AXI_WDATA),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write FSM next state: accept AW, absorb beats, then hold B until taken.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    wr_err_d   = wr_err_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_burst_d = wr_burst_q;
    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          bid_d      = S_AXI_AWID;
          wr_addr_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wr_len_d   = S_AXI_AWLEN;
          wr_burst_d = S_AXI_AWBURST;
          wr_cnt_d   = 8'd0;
          wr_err_d   = burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          wr_cnt_d = wr_cnt_q + 8'd1;
          if (wr_burst_q == INCR) wr_addr_d = wr_addr_q + WA'(1);
          if (S_AXI_WLAST || (wr_cnt_q == wr_len_q)) begin
            if (S_AXI_WLAST != (wr_cnt_q == wr_len_q)) wr_err_d = 1'b1;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      wr_err_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_len_q   <= 8'd0;
      wr_cnt_q   <= 8'd0;
      wr_burst_q <= FIXED;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      wr_err_q   <= wr_err_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_burst_q <= wr_burst_d;
    end
  end

  assign rd_next = (rd_burst_q == INCR) ? rd_addr_q + WA'(1) : rd_addr_q;

  // Read FSM next state: the RAM read for the next beat is issued on the
  // handshake edge so beats stream without bubbles; a stall freezes it.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rid_d      = rid_q;
    rd_err_d   = rd_err_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_burst_d = rd_burst_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_addr_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          rid_d      = S_AXI_ARID;
          rd_addr_d  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          rd_len_d   = S_AXI_ARLEN;
          rd_burst_d = S_AXI_ARBURST;
          rd_cnt_d   = 8'd0;
          rd_err_d   = burst_err(S_AXI_ARBURST, S_AXI_ARSIZE);
          ram_re     = 1'b1;
          ram_raddr  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          if (rd_cnt_q == rd_len_q) begin
            rvalid_d   = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = R_IDLE;
          end else begin
            rd_addr_d = rd_next;
            ram_raddr = rd_next;
            ram_re    = 1'b1;
            rd_cnt_d  = rd_cnt_q + 8'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rd_err_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_len_q   <= 8'd0;
      rd_cnt_q   <= 8'd0;
      rd_burst_q <= FIXED;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rd_err_q   <= rd_err_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_burst_q <= rd_burst_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = (bvalid_q && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RLAST   = rvalid_q && (rd_cnt_q == rd_len_q);
  assign S_AXI_RRESP   = (rvalid_q && rd_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RDATA   = (rvalid_q && !rd_err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Directed bench for axi4_burst_slave_mem: bursts, strobes, wrap-around,
// error responses, reset abort and backpressure.
module tb_axi4_burst_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  awid, bid, arid, rid;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [0:15];

  always #5 clk = ~clk;

  axi4_burst_slave_mem dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin tick(); n++; end
    check("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin tick(); n++; end
    check("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin tick(); n++; end
    check("w_ready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp_resp, input logic exp_id);
    int n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    check("b_valid", bvalid, 1);
    check("b_resp", bresp, exp_resp);
    check("b_id", bid, exp_id);
    tick();
    bready = 1'b0;
    check("b_awready_after", awready, 1);
  endtask

  // Expected beat data comes from exp_q (or zero on an error burst).
  task automatic do_read(input logic id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input logic err, input logic toggle);
    int k = 0;
    int cyc = 0;
    send_ar(id, addr, len, burst, size);
    while (k <= int'(len) && cyc < 200) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid === 1'b1) begin
        check($sformatf("r_data[%0d]", k), rdata, err ? 32'h0 : exp_q[k]);
        check($sformatf("r_last[%0d]", k), rlast, (k == int'(len)));
        check($sformatf("r_resp[%0d]", k), rresp, err ? 2'b10 : 2'b00);
        check($sformatf("r_id[%0d]", k), rid, id);
        if (rready) k++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", k, int'(len) + 1);
    check("r_idle_rvalid", rvalid, 0);
    check("r_idle_arready", arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_arready", arready, 1);

    // INCR write of 0x1..0x10 then read back.
    send_aw(1'b1, 12'h000, 8'd15, 2'b01, 3'd2);
    for (int i = 0; i < 16; i++) send_w(32'(i + 1), 4'hF, (i == 15));
    get_b(2'b00, 1'b1);
    for (int i = 0; i < 16; i++) exp_q[i] = 32'(i + 1);
    do_read(1'b1, 12'h000, 8'd15, 2'b01, 3'd2, 1'b0, 1'b0);

    // Reset during beat 3 of a 16-beat read.
    send_ar(1'b0, 12'h000, 8'd15, 2'b01, 3'd2);
    rready = 1'b1;
    tick();
    tick();
    check("midrst_pre_rvalid", rvalid, 1);
    check("midrst_pre_rdata", rdata, 32'h3);
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rlast", rlast, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_arready", arready, 0);
    check("midrst_awready", awready, 0);
    rready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("midrst_rel_awready", awready, 1);
    check("midrst_rel_arready", arready, 1);
    check("midrst_rel_rvalid", rvalid, 0);
    do_read(1'b0, 12'h000, 8'd15, 2'b01, 3'd2, 1'b0, 1'b0);

    // Byte strobes and address wrap-around from 0xFFC to 0x000.
    send_aw(1'b0, 12'hFFC, 8'd1, 2'b01, 3'd2);
    send_w(32'hFFFF_FFFF, 4'hF, 1'b0);
    send_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    get_b(2'b00, 1'b0);
    send_aw(1'b0, 12'hFFC, 8'd1, 2'b01, 3'd2);
    send_w(32'hAABB_CCDD, 4'b0101, 1'b0);
    send_w(32'hAABB_CCDD, 4'b0101, 1'b1);
    get_b(2'b00, 1'b0);
    exp_q[0] = 32'hFFBB_FFDD;
    exp_q[1] = 32'hFFBB_FFDD;
    do_read(1'b0, 12'hFFC, 8'd1, 2'b01, 3'd2, 1'b0, 1'b0);
    do_read(1'b1, 12'h000, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);

    // WRAP write is rejected and leaves the RAM untouched.
    send_aw(1'b0, 12'h100, 8'd0, 2'b01, 3'd2);
    send_w(32'hCAFE_F00D, 4'hF, 1'b1);
    get_b(2'b00, 1'b0);
    send_aw(1'b1, 12'h100, 8'd0, 2'b10, 3'd2);
    send_w(32'h1234_5678, 4'hF, 1'b1);
    get_b(2'b10, 1'b1);
    exp_q[0] = 32'hCAFE_F00D;
    do_read(1'b1, 12'h100, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);

    // Early WLAST on beat 2 of a 4-beat burst.
    send_aw(1'b0, 12'h200, 8'd3, 2'b01, 3'd2);
    send_w(32'h11, 4'hF, 1'b0);
    send_w(32'h22, 4'hF, 1'b1);
    check("early_wlast_wready", wready, 0);
    get_b(2'b10, 1'b0);

    // Illegal read size: four beats of zero data with SLVERR.
    do_read(1'b1, 12'h000, 8'd3, 2'b01, 3'd1, 1'b1, 1'b0);

    // RREADY toggling on an 8-beat read of words 1..8 (values 2..9).
    for (int i = 0; i < 8; i++) exp_q[i] = 32'(i + 2);
    do_read(1'b0, 12'h004, 8'd7, 2'b01, 3'd2, 1'b0, 1'b1);

    // BREADY held low for 20 cycles.
    send_aw(1'b1, 12'h300, 8'd0, 2'b01, 3'd2);
    send_w(32'h5A5A_5A5A, 4'hF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("bstall_bvalid", bvalid, 1);
      check("bstall_bresp", bresp, 2'b00);
      check("bstall_awready", awready, 0);
      tick();
    end
    get_b(2'b00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
